// File: rtl/alu_pkg.sv
// Shared opcode, flag, FSM-state and class definitions for the ALU execute controller.
package alu_pkg;

  localparam int unsigned FLAG_W = 5;

  localparam int unsigned FLAG_N = 0;
  localparam int unsigned FLAG_L = 1;
  localparam int unsigned FLAG_O = 2;
  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_Z = 4;

  localparam logic [FLAG_W-1:0] MASK_ARITH = 5'b11100;  // Z, C, O
  localparam logic [FLAG_W-1:0] MASK_CMP   = 5'b10011;  // Z, L, N

  localparam logic [7:0] OP_ADD    = 8'h05;
  localparam logic [7:0] OP_ADDU   = 8'h06;
  localparam logic [7:0] OP_ADDC   = 8'h07;
  localparam logic [7:0] OP_ADDCU  = 8'h04;
  localparam logic [7:0] OP_ADDI   = 8'h50;
  localparam logic [7:0] OP_ADDUI  = 8'h60;
  localparam logic [7:0] OP_ADDCI  = 8'h70;
  localparam logic [7:0] OP_ADDCUI = 8'h40;
  localparam logic [7:0] OP_SUB    = 8'h09;
  localparam logic [7:0] OP_SUBI   = 8'h90;
  localparam logic [7:0] OP_CMP    = 8'h0B;
  localparam logic [7:0] OP_CMPI   = 8'hB0;
  localparam logic [7:0] OP_CMPU   = 8'h08;
  localparam logic [7:0] OP_CMPUI  = 8'h0C;
  localparam logic [7:0] OP_AND    = 8'h01;
  localparam logic [7:0] OP_OR     = 8'h02;
  localparam logic [7:0] OP_XOR    = 8'h03;
  localparam logic [7:0] OP_NOT    = 8'h0F;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StExec,
    StWb
  } state_e;

  typedef enum logic [2:0] {
    ClsAdd,
    ClsSub,
    ClsCmp,
    ClsLogic,
    ClsIllegal
  } op_class_e;

  function automatic op_class_e op_class(input logic [7:0] op);
    op_class_e cls;
    case (op)
      OP_ADD, OP_ADDU, OP_ADDC, OP_ADDCU,
      OP_ADDI, OP_ADDUI, OP_ADDCI, OP_ADDCUI: cls = ClsAdd;
      OP_SUB, OP_SUBI:                        cls = ClsSub;
      OP_CMP, OP_CMPI, OP_CMPU, OP_CMPUI:     cls = ClsCmp;
      OP_AND, OP_OR, OP_XOR, OP_NOT:          cls = ClsLogic;
      default:                                cls = ClsIllegal;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: operand form, carry use, writeback and PSR flag mask.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [7:0]        opcode_i,
  output logic              is_imm_o,
  output logic              imm_signed_o,
  output logic              use_carry_o,
  output logic              writes_rd_o,
  output logic [FLAG_W-1:0] flag_mask_o,
  output logic              illegal_o
);

  op_class_e cls;

  always_comb begin
    cls          = op_class(opcode_i);
    is_imm_o     = 1'b0;
    imm_signed_o = 1'b0;
    use_carry_o  = 1'b0;
    writes_rd_o  = 1'b0;
    flag_mask_o  = '0;
    illegal_o    = 1'b0;

    case (cls)
      ClsAdd, ClsSub: begin
        writes_rd_o = 1'b1;
        flag_mask_o = MASK_ARITH;
      end
      ClsCmp:   flag_mask_o = MASK_CMP;
      ClsLogic: writes_rd_o = 1'b1;
      default:  illegal_o   = 1'b1;
    endcase

    case (opcode_i)
      OP_ADDI, OP_ADDCI, OP_SUBI, OP_CMPI: begin
        is_imm_o     = 1'b1;
        imm_signed_o = 1'b1;
      end
      OP_ADDUI, OP_ADDCUI, OP_CMPUI: is_imm_o = 1'b1;
      default: ;
    endcase

    case (opcode_i)
      OP_ADDC, OP_ADDCU, OP_ADDCI, OP_ADDCUI: use_carry_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute controller: sequences one instruction through the shared ALU
// (IDLE -> READ -> EXEC -> WB) and maintains the PSR flags.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned IMM_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [7:0]        instr_opcode,
  input  logic [REG_AW-1:0] instr_rdst,
  input  logic [REG_AW-1:0] instr_rsrc,
  input  logic [IMM_W-1:0]  instr_imm,
  output logic [REG_AW-1:0] rf_raddr_a,
  output logic [REG_AW-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [7:0]        alu_opcode,
  output logic              alu_carry_in,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [4:0]        alu_flags,
  output logic [4:0]        psr_flags,
  output logic              done,
  output logic              illegal_op
);

  state_e            state_q, state_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [REG_AW-1:0] rdst_q, rdst_d;
  logic [REG_AW-1:0] rsrc_q, rsrc_d;
  logic [IMM_W-1:0]  imm_q, imm_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [7:0]        alu_op_q, alu_op_d;
  logic              alu_cin_q, alu_cin_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [FLAG_W-1:0] res_flags_q, res_flags_d;
  logic [FLAG_W-1:0] psr_q, psr_d;

  logic              is_imm;
  logic              imm_signed;
  logic              use_carry;
  logic              writes_rd;
  logic [FLAG_W-1:0] flag_mask;
  logic              illegal;
  logic              accept;
  logic [DATA_W-1:0] imm_ext;

  alu_op_decode u_decode (
    .opcode_i     (opcode_q),
    .is_imm_o     (is_imm),
    .imm_signed_o (imm_signed),
    .use_carry_o  (use_carry),
    .writes_rd_o  (writes_rd),
    .flag_mask_o  (flag_mask),
    .illegal_o    (illegal)
  );

  assign accept  = (state_q == StIdle) && instr_valid;
  assign imm_ext = imm_signed ? {{(DATA_W-IMM_W){imm_q[IMM_W-1]}}, imm_q}
                              : {{(DATA_W-IMM_W){1'b0}}, imm_q};

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    rdst_d      = rdst_q;
    rsrc_d      = rsrc_q;
    imm_d       = imm_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    alu_op_d    = alu_op_q;
    alu_cin_d   = alu_cin_q;
    res_d       = res_q;
    res_flags_d = res_flags_q;
    psr_d       = psr_q;

    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          opcode_d = instr_opcode;
          rdst_d   = instr_rdst;
          rsrc_d   = instr_rsrc;
          imm_d    = instr_imm;
          state_d  = StRead;
        end
      end
      StRead: begin
        // ALU inputs are registered here so they stay stable outside EXEC.
        opa_d     = rf_rdata_a;
        opb_d     = is_imm ? imm_ext : rf_rdata_b;
        alu_op_d  = opcode_q;
        alu_cin_d = use_carry & psr_q[FLAG_C];
        state_d   = StExec;
      end
      StExec: begin
        res_d       = alu_c;
        res_flags_d = alu_flags;
        state_d     = StWb;
      end
      StWb: begin
        psr_d   = (psr_q & ~flag_mask) | (res_flags_q & flag_mask);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      opcode_q    <= '0;
      rdst_q      <= '0;
      rsrc_q      <= '0;
      imm_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      alu_op_q    <= '0;
      alu_cin_q   <= 1'b0;
      res_q       <= '0;
      res_flags_q <= '0;
      psr_q       <= '0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      rdst_q      <= rdst_d;
      rsrc_q      <= rsrc_d;
      imm_q       <= imm_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      alu_op_q    <= alu_op_d;
      alu_cin_q   <= alu_cin_d;
      res_q       <= res_d;
      res_flags_q <= res_flags_d;
      psr_q       <= psr_d;
    end
  end

  // Read addresses bypass the latch on the accept cycle so data lands in READ.
  assign rf_raddr_a   = accept ? instr_rdst : rdst_q;
  assign rf_raddr_b   = accept ? instr_rsrc : rsrc_q;
  assign instr_ready  = (state_q == StIdle);
  assign done         = (state_q == StWb);
  assign illegal_op   = done && illegal;
  assign rf_we        = done && writes_rd;
  assign rf_waddr     = rdst_q;
  assign rf_wdata     = res_q;
  assign alu_a        = opa_q;
  assign alu_b        = opb_q;
  assign alu_opcode   = alu_op_q;
  assign alu_carry_in = alu_cin_q;
  assign psr_flags    = psr_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural regfile and ALU around the DUT.
module tb_alu_exec_ctrl;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [3:0]  instr_rdst;
  logic [3:0]  instr_rsrc;
  logic [7:0]  instr_imm;
  logic [3:0]  rf_raddr_a;
  logic [3:0]  rf_raddr_b;
  logic [15:0] rf_rdata_a;
  logic [15:0] rf_rdata_b;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [7:0]  alu_opcode;
  logic        alu_carry_in;
  logic [15:0] alu_c;
  logic [4:0]  alu_flags;
  logic [4:0]  psr_flags;
  logic        done;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  alu_exec_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_rdst   (instr_rdst),
    .instr_rsrc   (instr_rsrc),
    .instr_imm    (instr_imm),
    .rf_raddr_a   (rf_raddr_a),
    .rf_raddr_b   (rf_raddr_b),
    .rf_rdata_a   (rf_rdata_a),
    .rf_rdata_b   (rf_rdata_b),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_carry_in (alu_carry_in),
    .alu_c        (alu_c),
    .alu_flags    (alu_flags),
    .psr_flags    (psr_flags),
    .done         (done),
    .illegal_op   (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous read, DUT write port plus a bench preload port.
  logic [15:0] regs [16];
  logic        tb_we;
  logic [3:0]  tb_wa;
  logic [15:0] tb_wd;

  always @(posedge clk) begin
    if (tb_we) regs[tb_wa] <= tb_wd;
    if (rf_we) regs[rf_waddr] <= rf_wdata;
  end

  always @(posedge clk) begin
    rf_rdata_a <= regs[rf_raddr_a];
    rf_rdata_b <= regs[rf_raddr_b];
  end

  // ALU model, flags [4]Z [3]C [2]O [1]L [0]N.
  logic [16:0] alu_s;
  always_comb begin
    alu_s     = '0;
    alu_c     = '0;
    alu_flags = '0;
    case (alu_opcode)
      8'h05, 8'h06, 8'h07, 8'h04, 8'h50, 8'h60, 8'h70, 8'h40: begin
        alu_s        = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_carry_in};
        alu_c        = alu_s[15:0];
        alu_flags[3] = alu_s[16];
        alu_flags[2] = (alu_a[15] == alu_b[15]) && (alu_s[15] != alu_a[15]);
      end
      8'h09, 8'h90: begin
        alu_s        = {1'b0, alu_a} - {1'b0, alu_b};
        alu_c        = alu_s[15:0];
        alu_flags[3] = alu_s[16];
        alu_flags[2] = (alu_a[15] != alu_b[15]) && (alu_s[15] != alu_a[15]);
      end
      8'h0B, 8'hB0: begin
        alu_flags[1] = alu_a < alu_b;
        alu_flags[0] = $signed(alu_a) < $signed(alu_b);
      end
      8'h08, 8'h0C: begin
        alu_flags[1] = alu_a < alu_b;
        alu_flags[0] = alu_a < alu_b;
      end
      8'h01: alu_c = alu_a & alu_b;
      8'h02: alu_c = alu_a | alu_b;
      8'h03: alu_c = alu_a ^ alu_b;
      8'h0F: alu_c = ~alu_a;
      default: ;
    endcase
    case (alu_opcode)
      8'h0B, 8'hB0, 8'h08, 8'h0C: alu_flags[4] = (alu_a == alu_b);
      default: begin
        alu_flags[4] = (alu_c == 16'd0);
        if (alu_opcode != 8'h0B) alu_flags[0] = alu_flags[0] | alu_c[15];
      end
    endcase
  end

  typedef struct packed {
    logic [7:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [7:0]  imm;
    logic        load;
    logic [15:0] va;
    logic [15:0] vb;
    logic [15:0] eb;
    logic        ecin;
    logic        ewe;
    logic [15:0] ewd;
    logic        eill;
    logic [4:0]  epsr;
  } vec_t;

  typedef struct packed {
    logic [3:0]  lat;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [7:0]  op;
    logic [3:0]  we_cnt;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        ill;
    logic        busy_rdy;
    logic [4:0]  psr;
    logic        rdy_after;
  } obs_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    tb_we = 1'b1;
    tb_wa = a;
    tb_wd = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  // Issues one instruction (waiting for ready) and observes it until the cycle after done.
  task automatic run_op(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [7:0] imm, input bit hold, output obs_t o);
    int n;
    o            = '0;
    instr_opcode = op;
    instr_rdst   = rd;
    instr_rsrc   = rs;
    instr_imm    = imm;
    instr_valid  = 1'b1;
    n = 0;
    while (!instr_ready && n < 8) begin
      @(posedge clk);
      #1 n++;
    end
    @(posedge clk);
    #1;
    if (!hold) instr_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (instr_ready) o.busy_rdy = 1'b1;
      if (c == 2) begin
        o.a   = alu_a;
        o.b   = alu_b;
        o.cin = alu_carry_in;
        o.op  = alu_opcode;
      end
      if (rf_we) begin
        o.we_cnt = o.we_cnt + 4'd1;
        o.waddr  = rf_waddr;
        o.wdata  = rf_wdata;
      end
      if (illegal_op) o.ill = 1'b1;
      if (done) begin
        o.lat = 4'(c);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    o.psr       = psr_flags;
    o.rdy_after = instr_ready;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    obs_t o;
    int   cnt;
    //            op     rd  rs  imm  ld  va        vb        eb        cin we  wdata     ill psr
    vecs[0]  = '{8'h05, 4'd1, 4'd2, 8'h00, 1'b1, 16'h7FFF, 16'h0001, 16'h0001, 1'b0, 1'b1,
                 16'h8000, 1'b0, 5'h04};
    vecs[1]  = '{8'h50, 4'd3, 4'd0, 8'hFF, 1'b1, 16'h0005, 16'h0000, 16'hFFFF, 1'b0, 1'b1,
                 16'h0004, 1'b0, 5'h08};
    vecs[2]  = '{8'h60, 4'd3, 4'd0, 8'hFF, 1'b1, 16'h0005, 16'h0000, 16'h00FF, 1'b0, 1'b1,
                 16'h0104, 1'b0, 5'h00};
    vecs[3]  = '{8'h05, 4'd4, 4'd5, 8'h00, 1'b1, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b1,
                 16'h0000, 1'b0, 5'h18};
    vecs[4]  = '{8'h07, 4'd6, 4'd7, 8'h00, 1'b0, 16'h0001, 16'h0001, 16'h0001, 1'b1, 1'b1,
                 16'h0003, 1'b0, 5'h00};
    vecs[5]  = '{8'h05, 4'd4, 4'd5, 8'h00, 1'b1, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b1,
                 16'h0000, 1'b0, 5'h18};
    vecs[6]  = '{8'h05, 4'd6, 4'd7, 8'h00, 1'b1, 16'h0001, 16'h0001, 16'h0001, 1'b0, 1'b1,
                 16'h0002, 1'b0, 5'h00};
    vecs[7]  = '{8'h05, 4'd4, 4'd5, 8'h00, 1'b1, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b1,
                 16'h0000, 1'b0, 5'h18};
    vecs[8]  = '{8'h0B, 4'd1, 4'd2, 8'h00, 1'b1, 16'h0001, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0,
                 16'h0000, 1'b0, 5'h0A};
    vecs[9]  = '{8'h01, 4'd10, 4'd11, 8'h00, 1'b1, 16'hF0F0, 16'h3C3C, 16'h3C3C, 1'b0, 1'b1,
                 16'h3030, 1'b0, 5'h0A};
    vecs[10] = '{8'hEE, 4'd12, 4'd13, 8'h00, 1'b1, 16'h1111, 16'h2222, 16'h2222, 1'b0, 1'b0,
                 16'h0000, 1'b1, 5'h0A};
    vecs[11] = '{8'h90, 4'd2, 4'd0, 8'h05, 1'b1, 16'h0005, 16'h0000, 16'h0005, 1'b0, 1'b1,
                 16'h0000, 1'b0, 5'h12};
    vecs[12] = '{8'h0C, 4'd2, 4'd0, 8'h80, 1'b1, 16'h0080, 16'h0000, 16'h0080, 1'b0, 1'b0,
                 16'h0000, 1'b0, 5'h10};
    vecs[13] = '{8'h0F, 4'd5, 4'd5, 8'h00, 1'b1, 16'h00FF, 16'h00FF, 16'h00FF, 1'b0, 1'b1,
                 16'hFF00, 1'b0, 5'h10};
    vecs[14] = '{8'h03, 4'd6, 4'd6, 8'h00, 1'b1, 16'hABCD, 16'hABCD, 16'hABCD, 1'b0, 1'b1,
                 16'h0000, 1'b0, 5'h10};
    vecs[15] = '{8'h70, 4'd7, 4'd0, 8'hFE, 1'b1, 16'h0010, 16'h0000, 16'hFFFE, 1'b0, 1'b1,
                 16'h000E, 1'b0, 5'h08};
    vecs[16] = '{8'h40, 4'd8, 4'd0, 8'hFF, 1'b1, 16'h0001, 16'h0000, 16'h00FF, 1'b1, 1'b1,
                 16'h0101, 1'b0, 5'h00};

    reset        = 1'b0;
    instr_valid  = 1'b0;
    instr_opcode = '0;
    instr_rdst   = '0;
    instr_rsrc   = '0;
    instr_imm    = '0;
    tb_we        = 1'b0;
    tb_wa        = '0;
    tb_wd        = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    chk("reset_ready", 32'(instr_ready), 32'd1);
    chk("reset_psr", 32'(psr_flags), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_we", 32'(rf_we), 32'd0);
    chk("reset_illegal", 32'(illegal_op), 32'd0);
    chk("reset_alu_a", 32'(alu_a), 32'd0);
    chk("reset_alu_op", 32'(alu_opcode), 32'd0);

    load(4'd6, 16'h0001);
    load(4'd7, 16'h0001);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].load) begin
        load(vecs[i].rd, vecs[i].va);
        load(vecs[i].rs, vecs[i].vb);
      end
      run_op(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm, 1'b0, o);
      chk($sformatf("v%0d_latency", i), 32'(o.lat), 32'd3);
      chk($sformatf("v%0d_busy_ready", i), 32'(o.busy_rdy), 32'd0);
      chk($sformatf("v%0d_alu_a", i), 32'(o.a), 32'(vecs[i].va));
      chk($sformatf("v%0d_alu_b", i), 32'(o.b), 32'(vecs[i].eb));
      chk($sformatf("v%0d_alu_opcode", i), 32'(o.op), 32'(vecs[i].op));
      chk($sformatf("v%0d_carry_in", i), 32'(o.cin), 32'(vecs[i].ecin));
      chk($sformatf("v%0d_we_count", i), 32'(o.we_cnt), 32'(vecs[i].ewe));
      if (vecs[i].ewe) begin
        chk($sformatf("v%0d_waddr", i), 32'(o.waddr), 32'(vecs[i].rd));
        chk($sformatf("v%0d_wdata", i), 32'(o.wdata), 32'(vecs[i].ewd));
      end
      chk($sformatf("v%0d_illegal", i), 32'(o.ill), 32'(vecs[i].eill));
      chk($sformatf("v%0d_psr", i), 32'(o.psr), 32'(vecs[i].epsr));
      chk($sformatf("v%0d_ready_after", i), 32'(o.rdy_after), 32'd1);
    end

    // instr_valid held across a whole instruction: exactly one re-accept per IDLE.
    load(4'd1, 16'h0001);
    load(4'd2, 16'h0002);
    run_op(8'h05, 4'd1, 4'd2, 8'h00, 1'b1, o);
    chk("hold_busy_ready", 32'(o.busy_rdy), 32'd0);
    chk("hold_wdata", 32'(o.wdata), 32'h0003);
    chk("hold_ready_after", 32'(o.rdy_after), 32'd1);
    run_op(8'h05, 4'd1, 4'd2, 8'h00, 1'b0, o);
    chk("hold2_latency", 32'(o.lat), 32'd3);
    chk("hold2_wdata", 32'(o.wdata), 32'h0005);

    // Reset while in EXEC aborts the instruction and clears the PSR.
    load(4'd4, 16'hFFFF);
    load(4'd5, 16'h0001);
    run_op(8'h05, 4'd4, 4'd5, 8'h00, 1'b0, o);
    chk("pre_reset_psr", 32'(o.psr), 32'h18);
    load(4'd1, 16'h0001);
    load(4'd2, 16'h0002);
    instr_opcode = 8'h05;
    instr_rdst   = 4'd1;
    instr_rsrc   = 4'd2;
    instr_valid  = 1'b1;
    @(posedge clk);
    #1 chk("abort_read_ready", 32'(instr_ready), 32'd0);
    @(posedge clk);
    #1 chk("abort_exec_ready", 32'(instr_ready), 32'd0);
    chk("abort_exec_alu_a", 32'(alu_a), 32'h0001);
    instr_valid = 1'b0;
    reset       = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_psr", 32'(psr_flags), 32'd0);
    chk("abort_we", 32'(rf_we), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_alu_a", 32'(alu_a), 32'd0);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (rf_we || done) cnt++;
      @(posedge clk);
      #1;
    end
    chk("abort_no_retire", 32'(cnt), 32'd0);
    chk("abort_reg_kept", 32'(regs[1]), 32'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Multi-cycle execute controller that sequences the shared 16-bit ALU for one instruction at a time. It accepts a decoded instruction from the decoder, reads operands from the register file and forms any immediate operand. It then drives the ALU, writes back the result, and maintains the processor status register (PSR) flags. It sits between the decoder/regfile and the combinational alu block.

Parameters:
DATA_W, 16, datapath width (ALU A/B/C)
REG_AW, 4, register address width (16 registers)
IMM_W, 8, immediate field width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
instr_valid  in  1  decoder offers an instruction
instr_ready  out  1  controller can accept (high only in IDLE)
instr_opcode  in  8  ALU opcode byte
instr_rdst  in  REG_AW  destination / A-operand register
instr_rsrc  in  REG_AW  source / B-operand register (ignored for immediates)
instr_imm  in  IMM_W  immediate field
rf_raddr_a  out  REG_AW  regfile read port A address
rf_raddr_b  out  REG_AW  regfile read port B address
rf_rdata_a  in  DATA_W  read data A (valid 1 cycle after address)
rf_rdata_b  in  DATA_W  read data B (valid 1 cycle after address)
rf_we  out  1  regfile write enable (one-cycle pulse)
rf_waddr  out  REG_AW  write address
rf_wdata  out  DATA_W  write data
alu_a  out  DATA_W  ALU A operand
alu_b  out  DATA_W  ALU B operand
alu_opcode  out  8  ALU opcode
alu_carry_in  out  1  ALU carryIn
alu_c  in  DATA_W  ALU result
alu_flags  in  5  ALU flags [4]Z [3]C [2]O [1]L [0]N
psr_flags  out  5  architectural flags, same bit order
done  out  1  one-cycle pulse on instruction retire
illegal_op  out  1  one-cycle pulse on retire of an unknown opcode

Behaviour:
- Reset (reset==0 at posedge): state=IDLE. All outputs are 0 except instr_ready=1. psr_flags=0. Operand and result registers are cleared. Reset mid-instruction aborts it with no write and no done.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE: instr_ready=1. A transfer occurs when instr_valid && instr_ready. The controller latches opcode/rdst/rsrc/imm, drives rf_raddr_a=rdst and rf_raddr_b=rsrc, and goes to READ.
- READ: captures rf_rdata_a into opA. opB = rf_rdata_b for register forms, or the extended immediate for immediate forms. Goes to EXEC.
- EXEC: drives alu_a=opA, alu_b=opB, alu_opcode=latched opcode, alu_carry_in. Captures alu_c and alu_flags into result registers. Goes to WB. Outside EXEC, alu_* outputs hold their last values.
- WB: drives rf_we=1 for writing ops, with rf_waddr=rdst and rf_wdata=result. Applies masked flag update to PSR. Pulses done, and pulses illegal_op if the opcode is unknown. Goes to IDLE.
- Latency: accept edge to done is 3 cycles. Throughput is one instruction per 4 cycles. instr_ready is 0 in READ/EXEC/WB.
- Opcode classes:
  - Register add: ADD 0x05, ADDU 0x06, ADDC 0x07, ADDCU 0x04.
  - Immediate add: ADDI 0x50, ADDUI 0x60, ADDCI 0x70, ADDCUI 0x40.
  - Subtract: SUB 0x09, SUBI 0x90.
  - Compare: CMP 0x0B, CMPI 0xB0, CMPU 0x08, CMPUI 0x0C.
  - Logic: AND 0x01, OR 0x02, XOR 0x03, NOT 0x0F.
- Immediate forms (ADDI, ADDCI, SUBI, CMPI) sign-extend imm to 16 bits. ADDUI, ADDCUI and CMPUI zero-extend it.
- alu_carry_in = psr_flags[3] for ADDC, ADDCU, ADDCI and ADDCUI. It is 0 for all other opcodes.
- Writeback: add, subtract and logic classes write back. Compare class and unknown opcodes never assert rf_we.
- Flag masks:
  - Add/sub: update C, O, Z.
  - Compare: update Z, L, N.
  - Logic: no update.
  - Unknown: no update.
  - Unmasked PSR bits hold their value.
- The flag update is visible on psr_flags the cycle after WB. An ADDC accepted immediately after retire sees the updated carry.
- NOT uses only opA; opB is don't-care.
- rdst==rsrc is legal; both operands read the same register.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams;
  - flag bit indices (FLAG_N=0, FLAG_L=1, FLAG_O=2, FLAG_C=3, FLAG_Z=4);
  - FSM state encoding;
  - class encoding.
- Sub-module alu_op_decode (combinational) maps the opcode to:
  - is_imm, imm_signed, use_carry, writes_rd, flag_mask[4:0], illegal.
- The FSM and registers live in alu_exec_ctrl. The real alu is instantiated in the bench, not inside the controller.

Test Plan:
- ADD, r1=0x7FFF, r2=0x0001 -> done exactly 3 cycles after accept. rf_we with waddr=1, wdata=0x8000. PSR O=1, C=0, Z=0.
- ADDI, r3=0x0005, imm=0xFF -> alu_b=0xFFFF, wdata=0x0004, C=1. ADDUI with the same inputs -> alu_b=0x00FF, wdata=0x0104.
- ADD 0xFFFF+0x0001 (C=1, Z=1), then back-to-back ADDC 0x0001+0x0001 -> alu_carry_in=1, wdata=0x0003. A following ADD drives alu_carry_in=0.
- CMP r1=0x0001, r2=0xFFFF after a carry-setting ADD -> rf_we never asserted. Z/L/N follow the ALU. PSR C remains 1.
- AND 0xF0F0 & 0x3C3C -> wdata=0x3030 with psr_flags unchanged. Opcode 0xEE -> illegal_op and done pulse, no rf_we, PSR unchanged.
- Drop reset for one cycle while in EXEC -> next cycle is IDLE with instr_ready=1, psr_flags=0, no rf_we and no done. instr_valid held high through the op is not re-accepted until IDLE.
